// File: rtl/code_sequencer.sv
// Instruction sequencer feeding the training controller from a small writable program.
// Optional watchdog enabled by defining SEQ_WATCHDOG_EN.
module code_sequencer #(
  parameter int unsigned OP_SIZE  = 4,
  parameter int unsigned SIZE     = 3,
  parameter int unsigned PROG_LEN = 4,
  parameter int unsigned EPOCHS   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        prog_we,
  input  logic [$clog2(PROG_LEN)-1:0] prog_addr,
  input  logic [OP_SIZE-1:0]          prog_op,
  input  logic [31:0]                 prog_layer,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        count_reset,
  input  logic                        code_active,
  input  logic                        code_reset,
  output logic [OP_SIZE-1:0]          op,
  output logic [31:0]                 code_count,
  output logic [31:0]                 code_index,
  output logic                        enable,
  output logic [31:0]                 epoch_left,
  output logic                        done,
  output logic                        hang
);

  localparam int unsigned AW = $clog2(PROG_LEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        epoch_q, epoch_d;
  logic [OP_SIZE-1:0] mem_op_q [PROG_LEN];
  logic [31:0]        mem_layer_q [PROG_LEN];
  logic               wd_trip;

`ifdef SEQ_WATCHDOG_EN
  localparam logic [31:0] WD_LIMIT = 32'(4 * SIZE - 1);
  logic hang_q;

  // Trips only on a silent cycle; any feedback takes its normal path instead.
  assign wd_trip = (state_q == RUN) && (count_q == WD_LIMIT) &&
                   !(abort || code_reset || code_active || count_reset);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hang_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      hang_q <= 1'b0;
    end else if (wd_trip) begin
      hang_q <= 1'b1;
    end
  end

  assign hang = hang_q;
`else
  assign wd_trip = 1'b0;
  assign hang    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    epoch_d = epoch_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          count_d = '0;
          epoch_d = 32'(EPOCHS);
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          pc_d    = '0;
          count_d = '0;
        end else if (code_reset) begin
          pc_d    = '0;
          count_d = '0;
          epoch_d = epoch_q - 32'd1;
          if (epoch_q == 32'd1) state_d = DONE;
        end else if (code_active) begin
          pc_d    = pc_q + 1'b1;
          count_d = '0;
        end else if (count_reset) begin
          count_d = '0;
        end else if (wd_trip) begin
          state_d = IDLE;
          pc_d    = '0;
          count_d = '0;
        end else if (count_q != 32'hFFFF_FFFF) begin
          count_d = count_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      count_q <= '0;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      epoch_q <= epoch_d;
    end
  end

  // Program store is only writable while idle so a running program never changes underfoot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PROG_LEN; i++) begin
        mem_op_q[i]    <= '0;
        mem_layer_q[i] <= '0;
      end
    end else if (state_q == IDLE && prog_we) begin
      mem_op_q[prog_addr]    <= prog_op;
      mem_layer_q[prog_addr] <= prog_layer;
    end
  end

  assign enable     = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign op         = enable ? mem_op_q[pc_q] : '0;
  assign code_index = enable ? mem_layer_q[pc_q] : '0;
  assign code_count = count_q;
  assign epoch_left = epoch_q;

endmodule
